// File: rtl/zipdbg_arbiter_if.sv
// Debug wishbone master bus between the arbiter and the ZipCPU debug slave.
// Handshake: an access is accepted on a clock edge where o_dbg_stb=1 and i_dbg_stall=0; its result
// arrives on a later edge (or the accepting edge itself) with i_dbg_ack=1, one access outstanding at a time.
interface zipdbg_arbiter_if;
  logic        o_dbg_cyc;
  logic        o_dbg_stb;
  logic        o_dbg_we;
  logic        o_dbg_addr;
  logic [31:0] o_dbg_data;
  logic        i_dbg_ack;
  logic        i_dbg_stall;
  logic [31:0] i_dbg_data;

  modport master (
    output o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr, o_dbg_data,
    input  i_dbg_ack, i_dbg_stall, i_dbg_data
  );

  modport slave (
    input  o_dbg_cyc, o_dbg_stb, o_dbg_we, o_dbg_addr, o_dbg_data,
    output i_dbg_ack, i_dbg_stall, i_dbg_data
  );
endinterface

// File: rtl/zipdbg_arbiter.sv
// Two-requester round-robin sequencer for ZipCPU debug register access:
// halt + select register, poll until stalled, move data, optionally release halt.
module zipdbg_arbiter #(
  parameter int POLL_MAX  = 15,
  parameter int LGTIMEOUT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a_req,
  input  logic             i_a_we,
  input  logic [4:0]       i_a_reg,
  input  logic [31:0]      i_a_data,
  input  logic             i_a_resume,
  output logic             o_a_done,
  input  logic             i_b_req,
  input  logic             i_b_we,
  input  logic [4:0]       i_b_reg,
  input  logic [31:0]      i_b_data,
  input  logic             i_b_resume,
  output logic             o_b_done,
  output logic [31:0]      o_rdata,
  output logic             o_err,
  output logic [2:0]       o_state,
  zipdbg_arbiter_if.master dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HALT   = 3'd1,
    S_POLL   = 3'd2,
    S_XFER   = 3'd3,
    S_RESUME = 3'd4,
    S_ERR    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                r_state;
  logic                  r_last_b;
  logic                  r_sel_b;
  logic                  r_we;
  logic                  r_resume;
  logic [4:0]            r_reg;
  logic [31:0]           r_wdata;
  logic [3:0]            r_poll;
  logic [LGTIMEOUT-1:0]  r_tmo;

  logic                  w_grant_a;
  logic                  w_grant_b;
  logic [4:0]            w_reg;
  logic                  w_bus;
  logic                  w_ack;
  logic                  w_tmo;

  // r_last_b resets high so A wins the first tie.
  assign w_grant_a = i_a_req && (!i_b_req || r_last_b);
  assign w_grant_b = i_b_req && !w_grant_a;
  assign w_reg     = w_grant_b ? i_b_reg : i_a_reg;
  assign w_bus     = (r_state == S_HALT) || (r_state == S_POLL) ||
                     (r_state == S_XFER) || (r_state == S_RESUME);
  assign w_ack     = dbg.i_dbg_ack && !(dbg.o_dbg_stb && dbg.i_dbg_stall);
  assign w_tmo     = &r_tmo;
  assign o_state   = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_last_b        <= 1'b1;
      r_sel_b         <= 1'b0;
      r_we            <= 1'b0;
      r_resume        <= 1'b0;
      r_reg           <= '0;
      r_wdata         <= '0;
      r_poll          <= '0;
      r_tmo           <= '0;
      o_a_done        <= 1'b0;
      o_b_done        <= 1'b0;
      o_rdata         <= '0;
      o_err           <= 1'b0;
      dbg.o_dbg_cyc   <= 1'b0;
      dbg.o_dbg_stb   <= 1'b0;
      dbg.o_dbg_we    <= 1'b0;
      dbg.o_dbg_addr  <= 1'b0;
      dbg.o_dbg_data  <= '0;
    end else begin
      o_a_done <= 1'b0;
      o_b_done <= 1'b0;
      if (dbg.o_dbg_stb && !dbg.i_dbg_stall) dbg.o_dbg_stb <= 1'b0;
      if (w_bus) r_tmo <= r_tmo + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_grant_a || w_grant_b) begin
            r_sel_b        <= w_grant_b;
            r_last_b       <= w_grant_b;
            r_we           <= w_grant_b ? i_b_we     : i_a_we;
            r_wdata        <= w_grant_b ? i_b_data   : i_a_data;
            r_resume       <= w_grant_b ? i_b_resume : i_a_resume;
            r_reg          <= w_reg;
            o_rdata        <= '0;
            dbg.o_dbg_cyc  <= 1'b1;
            dbg.o_dbg_stb  <= 1'b1;
            dbg.o_dbg_we   <= 1'b1;
            dbg.o_dbg_addr <= 1'b0;
            dbg.o_dbg_data <= 32'h400 | {27'h0, w_reg};
            r_tmo          <= '0;
            r_state        <= S_HALT;
          end
        end
        S_HALT: begin
          if (w_ack) begin
            r_poll         <= '0;
            dbg.o_dbg_stb  <= 1'b1;
            dbg.o_dbg_we   <= 1'b0;
            dbg.o_dbg_addr <= 1'b0;
            dbg.o_dbg_data <= '0;
            r_tmo          <= '0;
            r_state        <= S_POLL;
          end
        end
        S_POLL: begin
          if (w_ack) begin
            // Control bit 9 set means the CPU is halted and the data port is usable.
            if (dbg.i_dbg_data[9]) begin
              dbg.o_dbg_stb  <= 1'b1;
              dbg.o_dbg_we   <= r_we;
              dbg.o_dbg_addr <= 1'b1;
              dbg.o_dbg_data <= r_wdata;
              r_tmo          <= '0;
              r_state        <= S_XFER;
            end else if (r_poll == 4'(POLL_MAX)) begin
              dbg.o_dbg_cyc  <= 1'b0;
              dbg.o_dbg_stb  <= 1'b0;
              r_state        <= S_ERR;
            end else begin
              r_poll         <= r_poll + 1'b1;
              dbg.o_dbg_stb  <= 1'b1;
              r_tmo          <= '0;
            end
          end
        end
        S_XFER: begin
          if (w_ack) begin
            if (!r_we) o_rdata <= dbg.i_dbg_data;
            if (r_resume) begin
              dbg.o_dbg_stb  <= 1'b1;
              dbg.o_dbg_we   <= 1'b1;
              dbg.o_dbg_addr <= 1'b0;
              dbg.o_dbg_data <= {27'h0, r_reg};
              r_tmo          <= '0;
              r_state        <= S_RESUME;
            end else begin
              dbg.o_dbg_cyc  <= 1'b0;
              o_a_done       <= !r_sel_b;
              o_b_done       <= r_sel_b;
              r_state        <= S_DONE;
            end
          end
        end
        S_RESUME: begin
          if (w_ack) begin
            dbg.o_dbg_cyc <= 1'b0;
            o_a_done      <= !r_sel_b;
            o_b_done      <= r_sel_b;
            r_state       <= S_DONE;
          end
        end
        S_ERR: begin
          o_err    <= 1'b1;
          o_rdata  <= '0;
          o_a_done <= !r_sel_b;
          o_b_done <= r_sel_b;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          o_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A silent slave abandons the access regardless of which bus state is waiting.
      if (w_bus && !w_ack && w_tmo) begin
        dbg.o_dbg_cyc <= 1'b0;
        dbg.o_dbg_stb <= 1'b0;
        r_state       <= S_ERR;
      end
    end
  end

endmodule

// File: tb/tb_zipdbg_arbiter.sv
// Directed bench for zipdbg_arbiter with a one-access-at-a-time debug slave model.
module tb_zipdbg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req, a_we, a_resume, b_req, b_we, b_resume;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        a_done, b_done, err;
  logic [31:0] rdata;
  logic [2:0]  state;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [33:0] exp_q[$];
  logic [33:0] bus_q[$];
  bit          sl_noack = 1'b0;
  logic [31:0] sl_poll = 32'h200;
  logic [31:0] sl_rdata = 32'h0;

  zipdbg_arbiter_if bus ();

  zipdbg_arbiter #(.POLL_MAX(15), .LGTIMEOUT(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_a_req    (a_req),
    .i_a_we     (a_we),
    .i_a_reg    (a_reg),
    .i_a_data   (a_data),
    .i_a_resume (a_resume),
    .o_a_done   (a_done),
    .i_b_req    (b_req),
    .i_b_we     (b_we),
    .i_b_reg    (b_reg),
    .i_b_data   (b_data),
    .i_b_resume (b_resume),
    .o_b_done   (b_done),
    .o_rdata    (rdata),
    .o_err      (err),
    .o_state    (state),
    .dbg        (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  // Slave: logs every accepted access and acks it on the following cycle.
  always @(posedge clk) begin
    bus.i_dbg_ack <= 1'b0;
    if (bus.o_dbg_cyc && bus.o_dbg_stb && !bus.i_dbg_stall) begin
      bus_q.push_back({bus.o_dbg_we, bus.o_dbg_addr, bus.o_dbg_data});
      if (!sl_noack) begin
        bus.i_dbg_ack  <= 1'b1;
        bus.i_dbg_data <= bus.o_dbg_addr ? sl_rdata : sl_poll;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(a_done || b_done) && cnt < limit);
    check("done_seen", 64'(a_done | b_done), 64'd1);
  endtask

  task automatic check_bus(input string tag);
    check({tag, "_count"}, 64'(bus_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++)
      check($sformatf("%s_acc%0d", tag, i), 64'(bus_q[i]), 64'(exp_q[i]));
    bus_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    int stb_cycles;
    a_req = 0; a_we = 0; a_reg = 0; a_data = 0; a_resume = 0;
    b_req = 0; b_we = 0; b_reg = 0; b_data = 0; b_resume = 0;
    bus.i_dbg_stall = 1'b0;

    // reset state
    repeat (3) step();
    check("rst_cyc",   64'(bus.o_dbg_cyc), 64'd0);
    check("rst_stb",   64'(bus.o_dbg_stb), 64'd0);
    check("rst_done",  64'({a_done, b_done, err}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    rst_n = 1'b1;
    step();

    // A writes reg 5, no resume
    a_we = 1; a_reg = 5; a_data = 32'hDEADBEEF; a_resume = 0; a_req = 1;
    exp_q.push_back({1'b1, 1'b0, 32'h405});
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    exp_q.push_back({1'b1, 1'b1, 32'hDEADBEEF});
    wait_done(50, lat);
    check("wr_latency", 64'(lat), 64'd7);
    check("wr_done",    64'({a_done, b_done}), 64'b10);
    check("wr_err",     64'(err), 64'd0);
    check("wr_cyc",     64'(bus.o_dbg_cyc), 64'd0);
    a_req = 0;
    check_bus("wr");
    step();
    check("wr_pulse", 64'(a_done), 64'd0);
    check("wr_idle",  64'(state), 64'd0);

    // B reads reg 31 with resume
    sl_rdata = 32'h12345678;
    b_we = 0; b_reg = 31; b_data = 32'hCAFE0000; b_resume = 1; b_req = 1;
    exp_q.push_back({1'b1, 1'b0, 32'h41F});
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    exp_q.push_back({1'b0, 1'b1, 32'hCAFE0000});
    exp_q.push_back({1'b1, 1'b0, 32'h1F});
    wait_done(50, lat);
    check("rd_latency", 64'(lat), 64'd9);
    check("rd_done",    64'({a_done, b_done}), 64'b01);
    check("rd_rdata",   64'(rdata), 64'h12345678);
    check("rd_err",     64'(err), 64'd0);
    b_req = 0;
    check_bus("rd");
    step();

    // both held: strict alternation starting with A
    a_we = 0; a_reg = 1; a_resume = 0; b_we = 0; b_reg = 2; b_resume = 0;
    sl_rdata = 32'hA5A5A5A5;
    a_req = 1; b_req = 1;
    for (int i = 0; i < 4; i++) begin
      wait_done(50, lat);
      check($sformatf("rr_order%0d", i), 64'({a_done, b_done}), (i % 2 == 0) ? 64'b10 : 64'b01);
    end
    check("rr_rdata", 64'(rdata), 64'hA5A5A5A5);
    a_req = 0; b_req = 0;
    step();
    bus_q.delete();

    // poll never succeeds: 16 polls then error
    sl_poll = 32'h0;
    a_we = 1; a_reg = 7; a_data = 32'h11; a_req = 1;
    exp_q.push_back({1'b1, 1'b0, 32'h407});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 1'b0, 32'h0});
    wait_done(100, lat);
    check("poll_latency", 64'(lat), 64'd36);
    check("poll_done",    64'({a_done, b_done}), 64'b10);
    check("poll_err",     64'(err), 64'd1);
    check("poll_cyc",     64'(bus.o_dbg_cyc), 64'd0);
    check("poll_rdata",   64'(rdata), 64'd0);
    a_req = 0;
    check_bus("poll");
    step();
    check("poll_err_clr", 64'(err), 64'd0);
    sl_poll = 32'h200;

    // stalled halt write, then no ack ever
    bus.i_dbg_stall = 1'b1;
    sl_noack = 1'b1;
    a_we = 1; a_reg = 3; a_data = 32'h1; a_req = 1;
    exp_q.push_back({1'b1, 1'b0, 32'h403});
    stb_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.o_dbg_stb) stb_cycles++;
      if (i == 3) bus.i_dbg_stall = 1'b0;
    end
    check("stall_stb_cycles", 64'(stb_cycles), 64'd4);
    wait_done(400, lat);
    check("tmo_latency", 64'(lat + 6), 64'd258);
    check("tmo_done",    64'({a_done, b_done}), 64'b10);
    check("tmo_err",     64'(err), 64'd1);
    check("tmo_cyc",     64'(bus.o_dbg_cyc), 64'd0);
    a_req = 0;
    check_bus("stall");
    sl_noack = 1'b0;
    step();

    // reset during XFER
    a_we = 1; a_reg = 9; a_data = 32'h5; a_req = 1;
    repeat (5) step();
    check("xfer_state", 64'(state), 64'd3);
    check("xfer_cyc",   64'(bus.o_dbg_cyc), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bus",   64'({bus.o_dbg_cyc, bus.o_dbg_stb, bus.o_dbg_we, bus.o_dbg_addr}), 64'd0);
    check("arst_data",  64'(bus.o_dbg_data), 64'd0);
    check("arst_outs",  64'({a_done, b_done, err, state}), 64'd0);
    a_req = 0;
    step();
    #2;
    rst_n = 1'b1;
    step();
    step();
    check("arst_no_done", 64'({a_done, b_done}), 64'd0);
    bus_q.delete();
    a_we = 0; b_we = 0; a_req = 1; b_req = 1;
    wait_done(50, lat);
    check("post_rst_first", 64'({a_done, b_done}), 64'b10);
    check("post_rst_lat",   64'(lat), 64'd7);
    a_req = 0; b_req = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
